// File: rtl/piano_pkg.sv
// Shared definitions for the piano front end: key count, note FSM states and the
// half-period table indexed by key number (key 7 is the highest pitch).
package piano_pkg;

  localparam int unsigned NUM_KEYS = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    PLAYING = 1'b1
  } note_state_t;

  localparam int unsigned NOTE_COUNT [NUM_KEYS] = '{84, 75, 67, 63, 56, 50, 45, 42};

  function automatic int unsigned note_count_max();
    int unsigned m;
    m = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (NOTE_COUNT[i] > m) m = NOTE_COUNT[i];
    end
    return m;
  endfunction

endpackage

// File: rtl/piano_key_debounce.sv
// One key: 2-flop synchroniser followed by a tick-driven debouncer that flips its
// stable level after DEBOUNCE_SAMPLES consecutive differing samples.
module piano_key_debounce #(
  parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  input  logic i_tick,
  output logic o_stable
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SAMPLES + 1);

  logic [1:0]       r_sync;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync   <= '0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync <= {r_sync[0], i_key};
      if (i_tick) begin
        if (r_sync[1] != r_stable) begin
          // The sample that would bring the count to DEBOUNCE_SAMPLES flips instead.
          if (r_cnt == CNT_W'(DEBOUNCE_SAMPLES - 1)) begin
            r_stable <= ~r_stable;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/piano_key_scanner.sv
// Key scanner top: sample prescaler, per-key debouncers, highest-key priority select
// and the registered note outputs consumed by the tone generator.
module piano_key_scanner
  import piano_pkg::*;
#(
  parameter int unsigned NUM_KEYS         = 8,
  parameter int unsigned WIDTH_COUNTER    = 10,
  parameter int unsigned SAMPLE_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_KEYS-1:0]      i_keys_in,
  output logic [WIDTH_COUNTER-1:0] o_half_period,
  output logic                     o_note_on,
  output logic [2:0]               o_note_idx,
  output logic                     o_note_change
);

  localparam int unsigned PRESC_W = $clog2(SAMPLE_DIV);

  if (NUM_KEYS != piano_pkg::NUM_KEYS) begin : g_bad_num_keys
    $error("NUM_KEYS must match the note table size");
  end
  if (SAMPLE_DIV < 2) begin : g_bad_sample_div
    $error("SAMPLE_DIV must be at least 2");
  end
  if (DEBOUNCE_SAMPLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_SAMPLES must be at least 1");
  end
  if (64'(note_count_max()) >= (64'd1 << WIDTH_COUNTER)) begin : g_bad_width
    $error("NOTE_COUNT entry does not fit in WIDTH_COUNTER bits");
  end

  logic [PRESC_W-1:0]       r_presc;
  logic                     w_tick;
  logic [NUM_KEYS-1:0]      w_stable;
  logic                     w_any;
  logic [2:0]               w_sel;
  note_state_t              r_state;
  note_state_t              w_state_d;
  logic                     r_note_on;
  logic [2:0]               r_note_idx;
  logic [WIDTH_COUNTER-1:0] r_half_period;
  logic                     r_note_change;
  logic                     w_on_d;
  logic [2:0]               w_idx_d;
  logic [WIDTH_COUNTER-1:0] w_hp_d;
  logic                     w_change_d;

  assign w_tick = (r_presc == PRESC_W'(SAMPLE_DIV - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    piano_key_debounce #(
      .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
    ) u_debounce (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_key   (i_keys_in[g]),
      .i_tick  (w_tick),
      .o_stable(w_stable[g])
    );
  end

  // Ascending scan: the last pressed key seen is the highest one.
  always_comb begin
    w_any = |w_stable;
    w_sel = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (w_stable[i]) w_sel = 3'(i);
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE:    if (w_any)  w_state_d = PLAYING;
      PLAYING: if (!w_any) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
    w_on_d     = (w_state_d == PLAYING);
    w_idx_d    = w_on_d ? w_sel : 3'd0;
    w_hp_d     = w_on_d ? WIDTH_COUNTER'(NOTE_COUNT[w_sel]) : '0;
    w_change_d = (w_on_d != r_note_on) || (w_idx_d != r_note_idx);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_note_on     <= 1'b0;
      r_note_idx    <= '0;
      r_half_period <= '0;
      r_note_change <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_note_on     <= w_on_d;
      r_note_idx    <= w_idx_d;
      r_half_period <= w_hp_d;
      r_note_change <= w_change_d;
    end
  end

  assign o_half_period = r_half_period;
  assign o_note_on     = r_note_on;
  assign o_note_idx    = r_note_idx;
  assign o_note_change = r_note_change;

endmodule

// File: tb/tb_piano_key_scanner.sv
// Bench for piano_key_scanner with SAMPLE_DIV = 4 and DEBOUNCE_SAMPLES = 3.
module tb_piano_key_scanner;

  localparam int unsigned SD = 4;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic [7:0] keys = 8'h00;
  logic [9:0] hp;
  logic       on;
  logic [2:0] idx;
  logic       chg;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  piano_key_scanner #(
    .NUM_KEYS        (8),
    .WIDTH_COUNTER   (10),
    .SAMPLE_DIV      (SD),
    .DEBOUNCE_SAMPLES(3)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_keys_in    (keys),
    .o_half_period(hp),
    .o_note_on    (on),
    .o_note_idx   (idx),
    .o_note_change(chg)
  );

  int note_tbl [8] = '{84, 75, 67, 63, 56, 50, 45, 42};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int top_key(input logic [7:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Model: a key flips once its last three tick samples all disagree with it.
  logic [7:0] m_s0, m_s1, m_h0, m_h1, m_stable, m_flip;
  int         m_presc;
  logic       m_on;
  int         m_idx;
  logic       e_on, e_chg;
  int         e_idx, e_hp;

  assign m_flip = (m_s1 ^ m_stable) & (m_h0 ^ m_stable) & (m_h1 ^ m_stable);
  assign m_on   = |m_stable;
  assign m_idx  = m_on ? top_key(m_stable) : 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s0 <= '0; m_s1 <= '0; m_h0 <= '0; m_h1 <= '0; m_stable <= '0; m_presc <= 0;
      e_on <= 1'b0; e_chg <= 1'b0; e_idx <= 0; e_hp <= 0;
    end else begin
      e_on  <= m_on;
      e_idx <= m_idx;
      e_hp  <= m_on ? note_tbl[m_idx] : 0;
      e_chg <= (m_on != e_on) || (m_idx != e_idx);
      if (m_presc == SD - 1) begin
        m_stable <= m_stable ^ m_flip;
        m_h1     <= m_h0;
        m_h0     <= m_s1;
      end
      m_s1    <= m_s0;
      m_s0    <= keys;
      m_presc <= (m_presc == SD - 1) ? 0 : m_presc + 1;
    end
  end

  logic prev_chg = 1'b0;
  always @(negedge clk) begin
    chk("note_on", int'(on), int'(e_on));
    chk("note_idx", int'(idx), e_idx);
    chk("half_period", int'(hp), e_hp);
    chk("note_change", int'(chg), int'(e_chg));
    chk("no_double_pulse", int'(chg & prev_chg), 0);
    prev_chg <= chg;
    if (chg) pulses <= pulses + 1;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_for(input string name, input logic want_on, input int want_idx,
                          input int bound, output int n);
    n = 0;
    while (!(on == want_on && int'(idx) == want_idx) && n < bound) begin
      step();
      n++;
    end
    if (n >= bound) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got note_on=%0d idx=%0d expected note_on=%0d idx=%0d",
               name, on, idx, want_on, want_idx);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_on"}, int'(on), 0);
    chk({name, "_idx"}, int'(idx), 0);
    chk({name, "_hp"}, int'(hp), 0);
    chk({name, "_chg"}, int'(chg), 0);
  endtask

  initial begin
    int n;
    int p0;
    int on_seen;

    #1;
    rst  = 1'b1;
    keys = 8'hFF;
    repeat (3) step();
    chk_idle("reset_held");

    // Release with all keys held: sync 2 edges, ticks on edges 4/8/12, output on 13.
    p0  = pulses;
    rst = 1'b0;
    wait_for("rst_release", 1'b1, 7, 40, n);
    chk("rst_release_latency", n, 13);
    chk("all_keys_hp", int'(hp), 42);
    chk("rst_release_pulses", pulses - p0, 1);

    keys = 8'h00;
    wait_for("release_all_a", 1'b0, 0, 40, n);
    repeat (10) step();

    p0   = pulses;
    keys = 8'h01;
    wait_for("single", 1'b1, 0, 30, n);
    chk("single_latency_le15", int'(n <= 15), 1);
    repeat (20) step();
    chk("single_idx", int'(idx), 0);
    chk("single_hp", int'(hp), 84);
    chk("single_pulses", pulses - p0, 1);

    p0   = pulses;
    keys = 8'h00;
    wait_for("release_single", 1'b0, 0, 30, n);
    repeat (20) step();
    chk("release_hp", int'(hp), 0);
    chk("release_idx", int'(idx), 0);
    chk("release_pulses", pulses - p0, 1);

    // Each level of key 3 spans only two ticks.
    p0      = pulses;
    on_seen = 0;
    for (int c = 0; c < 200; c++) begin
      if (c % 8 == 0) keys = keys ^ 8'h08;
      step();
      if (on) on_seen = 1;
    end
    keys = 8'h00;
    repeat (20) step();
    chk("bounce_note_on_seen", on_seen, 0);
    chk("bounce_pulses", pulses - p0, 0);

    p0   = pulses;
    keys = 8'h24;
    wait_for("prio_2_5", 1'b1, 5, 30, n);
    repeat (20) step();
    chk("prio_idx5", int'(idx), 5);
    chk("prio_hp50", int'(hp), 50);
    chk("prio_press_pulses", pulses - p0, 1);

    p0   = pulses;
    keys = 8'h04;
    wait_for("prio_2", 1'b1, 2, 30, n);
    repeat (20) step();
    chk("prio_idx2", int'(idx), 2);
    chk("prio_hp67", int'(hp), 67);
    chk("prio_switch_pulses", pulses - p0, 1);

    p0   = pulses;
    keys = 8'h00;
    wait_for("prio_release", 1'b0, 0, 30, n);
    repeat (20) step();
    chk("idle_hp", int'(hp), 0);
    chk("idle_pulses", pulses - p0, 1);

    keys = 8'h80;
    wait_for("key7", 1'b1, 7, 30, n);
    chk("key7_hp", int'(hp), 42);
    repeat (5) step();
    keys = 8'h90;
    repeat (7) step();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("midrst");
    repeat (3) step();
    p0  = pulses;
    rst = 1'b0;
    wait_for("midrst_release", 1'b1, 7, 40, n);
    chk("midrst_latency", n, 13);
    chk("midrst_pulses", pulses - p0, 1);
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/piano_key_scanner.md
# piano_key_scanner

Upstream front end of the simple piano: synchronises and debounces the raw key inputs and selects the highest-pitch pressed key. It converts that key into the half-period divider count that the tone generator consumes. It also reports whether a note is sounding and flags every note change.

## Interface
Parameters:
- NUM_KEYS, 8: number of key inputs; fixed at 8 by the note table.
- WIDTH_COUNTER, 10: width of the half-period count; must match the tone generator.
- SAMPLE_DIV, 1000: clock cycles between debounce sample ticks; must be ≥ 2.
- DEBOUNCE_SAMPLES, 4: consecutive differing samples needed to flip a key's debounced state; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- keys_in  in  NUM_KEYS  raw key levels, 1 = pressed; asynchronous to clk.
- half_period  out  WIDTH_COUNTER  divider count for the selected note; 0 when no note is sounding.
- note_on  out  1  high while any debounced key is pressed.
- note_idx  out  3  index of the selected key; 0 when note_on = 0.
- note_change  out  1  one-cycle pulse whenever the {note_on, note_idx} pair changes.

## Operation
- Synchroniser: each keys_in bit passes through a 2-flop synchroniser, reset to 0.
- Prescaler:
  - Counts 0..SAMPLE_DIV-1 and wraps to 0.
  - tick is high for exactly the one cycle in which the count equals SAMPLE_DIV-1.
- Per-key debouncer, which holds a stable bit and a sample counter:
  - On a tick where the synchronised bit ≠ stable, the counter increments.
  - When the counter would reach DEBOUNCE_SAMPLES, stable toggles and the counter clears.
  - On a tick where the synchronised bit = stable, the counter clears.
  - Between ticks, nothing changes.
- Selection: the highest pressed stable index wins (key 7 has the highest pitch). Lower keys are ignored while a higher key is held.
- The note FSM has two states:
  - IDLE: note_on = 0, note_idx = 0, half_period = 0. Goes to PLAYING on the cycle after any stable bit becomes 1.
  - PLAYING: note_on = 1, note_idx = selected index, half_period = NOTE_COUNT[note_idx].
    - If the selection changes while keys are still pressed, it stays in PLAYING and updates note_idx and half_period.
    - When all stable bits are 0, it goes to IDLE.
- note_change: registered alongside the outputs. It is high for the one cycle in which the outputs first take a new {note_on, note_idx} value.
  - It is high on entry to PLAYING, on exit to IDLE, and on a note switch within PLAYING.
  - It is never high twice in a row.
- Simultaneous events:
  - Several keys may flip on the same tick; the selection is evaluated once, from the post-tick stable vector.
  - If a press and a release on the same tick leave the winner unchanged, no pulse is generated.
- Width rules:
  - The prescaler is clog2(SAMPLE_DIV) bits and the debounce counter is clog2(DEBOUNCE_SAMPLES+1) bits.
  - Every NOTE_COUNT entry must fit in WIDTH_COUNTER; this is checked by an elaboration assertion.

## Timing
- Reset values: all outputs, synchroniser flops, stable bits, counters and the prescaler are 0; the FSM is in IDLE.
  - Reset is asynchronous: outputs go to 0 as soon as rst is asserted, including in the middle of a debounce or while PLAYING.
  - No note_change pulse is issued on reset entry or on reset exit.
- Latency from a keys_in edge to the output update:
  - 2 cycles of synchronisation.
  - Then DEBOUNCE_SAMPLES ticks; the stable bit updates on the last of these tick cycles.
  - Then +1 cycle for the output register.
  - Worst case: 2 + DEBOUNCE_SAMPLES·SAMPLE_DIV + 1 cycles.
- There is no handshake: half_period is level-valid on every cycle, and the tone generator samples it freely.

## Structure
- Package piano_pkg holds:
  - NUM_KEYS.
  - The note_state_t enum {IDLE, PLAYING}.
  - The NOTE_COUNT array, indices 0..7 = 84, 75, 67, 63, 56, 50, 45, 42.
- Sub-module piano_key_debounce: one synchroniser plus one debouncer for a single key, with tick as an input. It is instantiated NUM_KEYS times.
- The top level holds the prescaler, priority encoder, FSM and output registers.

## Test plan
All scenarios use SAMPLE_DIV = 4 and DEBOUNCE_SAMPLES = 3.
- Reset: assert rst with keys_in = 8'hFF → all outputs 0. Release rst → outputs stay 0 until debounce completes, and no note_change pulse occurs at reset release.
- Single key: hold keys_in = 8'h01 → note_on = 1, note_idx = 0, half_period = 84 within 2 + 12 + 1 cycles, with exactly one note_change pulse.
- Bounce: toggle key 3 every 8 cycles (each level lasts 2 ticks, fewer than 3) for 200 cycles → note_on stays 0 and note_change never pulses.
- Priority:
  - Hold keys 2 and 5 → note_idx = 5, half_period = 50.
  - Release key 5 → note_idx = 2, half_period = 67.
  - Each transition produces exactly one pulse.
- Release all keys from PLAYING → IDLE with half_period = 0, note_idx = 0, and one note_change pulse.
- Mid-operation reset: assert rst while PLAYING key 7 and while key 4 is half-debounced → outputs are 0 immediately. After release, with keys held, the full debounce latency is required again.
